// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues request-to-send,
// shifts a byte + odd parity + stop on device clock falls, then checks the ACK.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_busy,
    output logic       o_done,
    output logic [1:0] o_status,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic       o_ps2_clk_oe,
    output logic       o_ps2_data_oe
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [1:0] ST_ACK     = 2'b00;
    localparam logic [1:0] ST_NACK    = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_RTS, S_SEND, S_ACK, S_RELEASE, S_DONE
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       bit_cnt, bit_cnt_n;
    logic [8:0]       shreg, shreg_n;
    logic             clk_oe_q, clk_oe_n;
    logic             data_oe_q, data_oe_n;
    logic [1:0]       status_q, status_n;

    logic [1:0]       clk_sync, data_sync;
    logic             clk_prev;
    logic             fall, timeout_hit;

    // Synchronizers start at the idle (released) level so reset never fakes a fall.
    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments make every flop sample the pre-edge value.
        if (i_rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], i_ps2_clk};
            data_sync <= {data_sync[0], i_ps2_data};
            clk_prev  <= clk_sync[1];
        end
    end

    assign fall        = clk_prev & ~clk_sync[1];
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            status_q  <= ST_ACK;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_cnt   <= bit_cnt_n;
            shreg     <= shreg_n;
            clk_oe_q  <= clk_oe_n;
            data_oe_q <= data_oe_n;
            status_q  <= status_n;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        state_n   = state;
        cnt_n     = cnt;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        clk_oe_n  = clk_oe_q;
        data_oe_n = data_oe_q;
        status_n  = status_q;

        unique case (state)
            S_IDLE: begin
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
                if (i_valid) begin
                    shreg_n  = {~^i_data, i_data};
                    status_n = ST_ACK;
                    cnt_n    = '0;
                    clk_oe_n = 1'b1;
                    state_n  = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
                    cnt_n     = '0;
                    data_oe_n = 1'b1;
                    state_n   = S_RTS;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_RTS: begin
                // Releasing the clock with data held low is the start bit.
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b1;
                bit_cnt_n = '0;
                cnt_n     = '0;
                state_n   = S_SEND;
            end
            S_SEND: begin
                if (fall) begin
                    cnt_n     = '0;
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (bit_cnt == 4'd9) begin
                        data_oe_n = 1'b0;
                        state_n   = S_ACK;
                    end else begin
                        data_oe_n = ~shreg[0];
                        shreg_n   = {1'b0, shreg[8:1]};
                    end
                end else if (timeout_hit) begin
                    data_oe_n = 1'b0;
                    status_n  = ST_TIMEOUT;
                    state_n   = S_DONE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_ACK: begin
                if (fall) begin
                    cnt_n    = '0;
                    status_n = data_sync[1] ? ST_NACK : ST_ACK;
                    state_n  = S_RELEASE;
                end else if (timeout_hit) begin
                    status_n = ST_TIMEOUT;
                    state_n  = S_DONE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_RELEASE: begin
                if (clk_sync[1] && data_sync[1]) begin
                    state_n = S_DONE;
                end else if (timeout_hit) begin
                    status_n = ST_TIMEOUT;
                    state_n  = S_DONE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_DONE: begin
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
                state_n   = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign o_ready       = (state == S_IDLE);
    assign o_busy        = ~o_ready;
    assign o_done        = (state == S_DONE);
    assign o_status      = status_q;
    assign o_ps2_clk_oe  = clk_oe_q;
    assign o_ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device on the open-drain lines.
module tb_ps2_host_tx;

    localparam int INH = 50;
    localparam int TMO = 100;

    logic       i_clk   = 1'b0;
    logic       i_rst   = 1'b1;
    logic       i_valid = 1'b0;
    logic [7:0] i_data  = 8'h00;
    logic       o_ready, o_busy, o_done;
    logic [1:0] o_status;
    logic       o_ps2_clk_oe, o_ps2_data_oe;
    logic       dev_clk  = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk, ps2_data;

    int tests  = 0;
    int failed = 0;

    assign ps2_clk  = dev_clk  & ~o_ps2_clk_oe;
    assign ps2_data = dev_data & ~o_ps2_data_oe;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_valid      (i_valid),
        .i_data       (i_data),
        .o_ready      (o_ready),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_status     (o_status),
        .i_ps2_clk    (ps2_clk),
        .i_ps2_data   (ps2_data),
        .o_ps2_clk_oe (o_ps2_clk_oe),
        .o_ps2_data_oe(o_ps2_data_oe)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Device clock: 10 high / 10 low; samples data just before each fall.
    task automatic dev_frame(output logic [10:0] bits, input bit ack, input int n_edges);
        bits = '0;
        for (int k = 0; k < n_edges; k++) begin
            repeat (10) @(negedge i_clk);
            bits[k] = ps2_data;
            if (k == 10 && ack) begin
                dev_data = 1'b0;
                repeat (5) @(negedge i_clk);
            end
            dev_clk = 1'b0;
            repeat (10) @(negedge i_clk);
            dev_clk = 1'b1;
        end
        dev_data = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input logic par, input bit ack, input bit inject,
                        input logic [1:0] exp_st, input string tag);
        logic [10:0] bits;
        int n, extra;
        @(negedge i_clk);
        check({tag, " ready"}, o_ready, 1'b1);
        i_valid = 1'b1;
        i_data  = b;
        @(negedge i_clk);
        i_valid = 1'b0;
        n = 0;
        while (o_ps2_clk_oe && !o_ps2_data_oe && n < INH + 10) begin
            n++;
            i_valid = inject && (n == 10);
            i_data  = 8'hAA;
            @(negedge i_clk);
        end
        i_valid = 1'b0;
        check({tag, " inhibit"}, n, INH);
        n = 0;
        while (o_ps2_clk_oe && o_ps2_data_oe && n < 10) begin
            n++;
            @(negedge i_clk);
        end
        check({tag, " rts"}, n, 1);
        check({tag, " start"}, {o_ps2_clk_oe, o_ps2_data_oe}, 2'b01);
        dev_frame(bits, ack, 11);
        check({tag, " bits"}, bits, {1'b1, par, b, 1'b0});
        n = 0;
        while (!o_done && n < 100) begin
            n++;
            @(negedge i_clk);
        end
        check({tag, " done"}, o_done, 1'b1);
        check({tag, " status"}, o_status, exp_st);
        @(negedge i_clk);
        check({tag, " done pulse"}, o_done, 1'b0);
        check({tag, " idle oe/ready"}, {o_ps2_clk_oe, o_ps2_data_oe, o_ready}, 3'b001);
        extra = 0;
        repeat (30) begin
            @(negedge i_clk);
            if (o_done) extra++;
        end
        check({tag, " extra done"}, extra, 0);
        check({tag, " status held"}, o_status, exp_st);
    endtask

    initial begin
        logic [10:0] bits;
        int n, extra;

        repeat (3) @(negedge i_clk);
        check("reset ready/busy/done", {o_ready, o_busy, o_done}, 3'b100);
        check("reset status", o_status, 2'b00);
        check("reset oe", {o_ps2_clk_oe, o_ps2_data_oe}, 2'b00);
        i_rst = 1'b0;

        send(8'hED, 1'b1, 1'b1, 1'b0, 2'b00, "ED");
        send(8'h00, 1'b1, 1'b1, 1'b0, 2'b00, "00");
        send(8'hFF, 1'b1, 1'b1, 1'b0, 2'b00, "FF");
        send(8'h01, 1'b0, 1'b1, 1'b0, 2'b00, "01");
        send(8'h3A, 1'b1, 1'b0, 1'b0, 2'b01, "nack");

        // Device never clocks: abort after inhibit + RTS + timeout window.
        @(negedge i_clk);
        check("tmo ready", o_ready, 1'b1);
        i_valid = 1'b1;
        i_data  = 8'h3C;
        @(negedge i_clk);
        i_valid = 1'b0;
        n = 0;
        while (!o_done && n < INH + TMO + 50) begin
            n++;
            @(negedge i_clk);
        end
        check("tmo latency", n, INH + 1 + TMO);
        check("tmo status", o_status, 2'b10);
        check("tmo oe", {o_ps2_clk_oe, o_ps2_data_oe}, 2'b00);
        @(negedge i_clk);
        check("tmo done pulse", o_done, 1'b0);

        // Reset after four device clock falls.
        i_valid = 1'b1;
        i_data  = 8'h12;
        @(negedge i_clk);
        i_valid = 1'b0;
        n = 0;
        while (!(!o_ps2_clk_oe && o_ps2_data_oe) && n < INH + 20) begin
            n++;
            @(negedge i_clk);
        end
        check("rst reach send", {o_ps2_clk_oe, o_ps2_data_oe}, 2'b01);
        dev_frame(bits, 1'b0, 4);
        check("rst bits so far", bits[3:0], 4'b0100);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        check("rst oe/ready/done", {o_ps2_clk_oe, o_ps2_data_oe, o_ready, o_done}, 4'b0010);
        extra = 0;
        repeat (30) begin
            @(negedge i_clk);
            if (o_done) extra++;
        end
        check("rst no done", extra, 0);
        send(8'hF4, 1'b0, 1'b1, 1'b0, 2'b00, "F4");

        // 0xAA offered mid-transfer must be ignored.
        send(8'h55, 1'b1, 1'b1, 1'b1, 2'b00, "busy55");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-side PS/2 host-to-device transmitter. It sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the CPU/peripheral bus to the keyboard.
- It is the reverse direction of the keyboard-to-host path. It shares the open-drain kbd clock/data pair with the existing PS/2 receiver, which must ignore the lines while o_busy=1.
- Sequence: inhibits the clock, issues request-to-send, shifts data/parity/stop on device-generated falling edges, checks the device ACK, and reports status.

Parameters:
- INHIBIT_CYCLES, 5000, i_clk cycles the clock line is held low before request-to-send (≥100 us at system clock).
- TIMEOUT_CYCLES, 100000, max i_clk cycles between detected device falling edges (and for final line release) before abort.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous reset, active-high
- i_valid  in  1  byte offer; accepted when i_valid & o_ready
- i_data  in  8  byte to send
- o_ready  out  1  high only in IDLE
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse at end of every accepted transfer
- o_status  out  2  valid with o_done, held until next accept: 00 ACK ok, 01 NACK, 10 timeout
- i_ps2_clk  in  1  raw PS/2 clock line (asynchronous)
- i_ps2_data  in  1  raw PS/2 data line (asynchronous)
- o_ps2_clk_oe  out  1  1 = pull clock low, 0 = release
- o_ps2_data_oe  out  1  1 = pull data low, 0 = release

Behaviour:
- Reset (i_rst sampled high): state IDLE, all counters 0.
  - Reset outputs: o_ready=1, o_busy=0, o_done=0, o_status=00, both oe=0, shift reg=0.
  - Reset mid-transfer releases both lines at that edge. No o_done is pulsed.
- Input sync: i_ps2_clk and i_ps2_data each pass through a 2-flop synchronizer.
  - Falling edge = prev synced clk 1, current synced clk 0.
  - Data line changes 3 i_clk cycles after the raw clock fall.
- Accept: in IDLE with i_valid=1:
  - Latch i_data and compute parity = ~^i_data (odd parity).
  - Clear o_status; go to INHIBIT. o_ready drops on the next cycle.
  - i_valid is ignored outside IDLE.
- FSM states and transitions:
  - IDLE: both oe=0.
  - INHIBIT: clk_oe=1, data_oe=0 for exactly INHIBIT_CYCLES cycles, then go to RTS.
  - RTS: clk_oe=1, data_oe=1 for 1 cycle, then go to SEND.
  - SEND: clk_oe=0; data_oe holds the start bit (low). Bit counter n=0.
    - On each detected falling edge, n increments, and data_oe is set per the falling-edge schedule below.
  - ACK: entered on falling edge 10 with data_oe=0.
    - On falling edge 11, sample synced data: 0 → status 00, 1 → status 01. Go to RELEASE.
  - RELEASE: wait until synced clk=1 and synced data=1, then go to DONE.
  - DONE: 1 cycle; o_done=1; go to IDLE.
- Falling-edge schedule in SEND (data_oe is the inverse of the bit value):
  - edges 1–8: drive data bits, LSB first.
  - edge 9: drive parity.
  - edge 10: stop bit, i.e. data_oe=0 (release); go to ACK.
- Timeout:
  - Counter clears on state entry and on every detected falling edge; counts in SEND, ACK and RELEASE.
  - On reaching TIMEOUT_CYCLES: both oe=0, status 10, go to DONE.
- Simultaneous events:
  - Timeout and falling edge in the same cycle: the edge wins.
  - i_rst beats every other event.
- Back-to-back transfers: o_ready returns the cycle after DONE. Minimum spacing between accepts is INHIBIT_CYCLES+4 plus the frame.
- Both oe outputs are registered; no combinational path from the inputs.

Test Plan:
- Send 0xED with a device responder (clock period 20 i_clk cycles, ACK low on edge 11):
  - Expect clk_oe=1 for exactly 5000 cycles, then data_oe=1 while clk_oe=1 for 1 cycle.
  - Device-sampled bits 0,1,0,1,1,0,1,1,1,1,1: start, LSB-first data (1,0,1,1,0,1,1,1), parity 1, stop 1.
  - o_done pulse with o_status=00.
- Send 0x00 → parity 1. Send 0xFF → parity 1. Send 0x01 → parity 0. Each ends with o_status=00.
- NACK: device leaves data high on edge 11 → o_done, o_status=01; both oe=0 after the pulse.
- Timeout: device never clocks → o_done exactly INHIBIT_CYCLES+1+TIMEOUT_CYCLES(+sync) cycles after accept, o_status=10, both oe=0.
- Reset mid-byte: assert i_rst after falling edge 4 → next cycle both oe=0, o_ready=1, no o_done. A new send of 0xF4 then completes with o_status=00.
- Busy ignore: pulse i_valid with 0xAA during a 0x55 transfer → only 0x55 is transmitted, exactly one o_done.
